// File: rtl/sound_pkg.sv
// Shared definitions for the note sequencer and the downstream sound generator:
// sequencer state encoding, song entry layout and the rest note code.
package sound_pkg;

  localparam int NOTE_W = 5;
  localparam int DUR_W  = 4;

  // Note index 0 is silence for the sound generator.
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE,
    ST_DONE
  } seq_state_t;

  // One song table entry; the entry lasts dur+1 ticks.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } song_entry_t;

endpackage

// File: rtl/note_sequencer_tempo_tick.sv
// Tempo prescaler: counts clock cycles while enabled and emits a one-cycle
// tick on the cycle the count wraps, i.e. once every TICK_DIV enabled cycles.
module tempo_tick #(
  parameter int TICK_DIV = 6_250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == PRE_MAX);

  // Prescaler count: cleared by reset or clr, frozen while en is low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every register
    // samples the values from before the edge, independent of block order.
    if (rst || clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: walks a constant song table at a tick-based tempo and
// drives the note index consumed by the sound generator.
module note_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_DIV = 6_250_000,
  parameter int SONG_LEN = 32,
  parameter int LOOP     = 1,
  parameter int ARTIC    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       restart,
  output logic [4:0] note,
  output logic [4:0] step,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LAST = 5'(SONG_LEN - 1);

  seq_state_t        state;
  logic [DUR_W-1:0]  rem;
  logic              tick;
  logic [4:0]        adv_step;
  logic [DUR_W-1:0]  adv_rem;
  logic              finish;
  song_entry_t       first_entry;
  song_entry_t       next_entry;
  song_entry_t       adv_entry;
  logic [NOTE_W-1:0] adv_note;

  // Song ROM. Entries beyond SONG_LEN-1 are never addressed.
  function automatic song_entry_t song_rom(input logic [4:0] idx);
    song_entry_t e;
    case (idx)
      5'd0:  e = {5'd3,  4'd1};
      5'd1:  e = {5'd7,  4'd0};
      5'd2:  e = {5'd12, 4'd2};
      5'd3:  e = {5'd5,  4'd0};
      5'd4:  e = {5'd8,  4'd1};
      5'd5:  e = {5'd10, 4'd1};
      5'd6:  e = {5'd12, 4'd3};
      5'd7:  e = {5'd0,  4'd1};
      5'd8:  e = {5'd12, 4'd1};
      5'd9:  e = {5'd10, 4'd0};
      5'd10: e = {5'd8,  4'd0};
      5'd11: e = {5'd7,  4'd1};
      5'd12: e = {5'd5,  4'd3};
      5'd13: e = {5'd0,  4'd1};
      5'd14: e = {5'd3,  4'd1};
      5'd15: e = {5'd5,  4'd1};
      5'd16: e = {5'd7,  4'd1};
      5'd17: e = {5'd8,  4'd1};
      5'd18: e = {5'd10, 4'd3};
      5'd19: e = {5'd8,  4'd1};
      5'd20: e = {5'd7,  4'd0};
      5'd21: e = {5'd5,  4'd0};
      5'd22: e = {5'd3,  4'd1};
      5'd23: e = {5'd0,  4'd0};
      5'd24: e = {5'd12, 4'd1};
      5'd25: e = {5'd15, 4'd1};
      5'd26: e = {5'd17, 4'd3};
      5'd27: e = {5'd15, 4'd1};
      5'd28: e = {5'd12, 4'd1};
      5'd29: e = {5'd10, 4'd1};
      5'd30: e = {5'd8,  4'd1};
      default: e = {5'd3, 4'd7};
    endcase
    return e;
  endfunction

  // Audible note for an entry given its remaining ticks: the last tick of a
  // multi-tick entry is silenced when articulation is on.
  function automatic logic [NOTE_W-1:0] voiced(input song_entry_t e,
                                               input logic [DUR_W-1:0] r);
    return (ARTIC != 0 && e.dur != '0 && r == '0) ? NOTE_REST : e.note;
  endfunction

  tempo_tick #(.TICK_DIV(TICK_DIV)) u_tempo (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_PLAY),
    .clr  ((state == ST_IDLE) || restart),
    .tick (tick)
  );

  assign first_entry = song_rom(5'd0);
  assign next_entry  = song_rom(step + 5'd1);
  assign adv_entry   = song_rom(adv_step);
  assign adv_note    = voiced(adv_entry, adv_rem);

  // Position after this cycle's tick, if any: count down, advance or wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    adv_step = step;
    adv_rem  = rem;
    finish   = 1'b0;
    if (tick) begin
      if (rem != '0) begin
        adv_rem = rem - 4'd1;
      end else if (step == LAST) begin
        if (LOOP != 0) begin
          adv_step = 5'd0;
          adv_rem  = first_entry.dur;
        end else begin
          finish = 1'b1;
        end
      end else begin
        adv_step = step + 5'd1;
        adv_rem  = next_entry.dur;
      end
    end
  end

  // Playback FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      note  <= NOTE_REST;
      step  <= 5'd0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (restart) begin
        step <= 5'd0;
        rem  <= first_entry.dur;
        if (play) begin
          state <= ST_PLAY;
          note  <= voiced(first_entry, first_entry.dur);
          busy  <= 1'b1;
        end else begin
          state <= ST_IDLE;
          note  <= NOTE_REST;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            step <= 5'd0;
            if (play) begin
              state <= ST_PLAY;
              rem   <= first_entry.dur;
              note  <= voiced(first_entry, first_entry.dur);
              busy  <= 1'b1;
            end else begin
              note <= NOTE_REST;
              busy <= 1'b0;
            end
          end
          ST_PLAY: begin
            step <= adv_step;
            rem  <= adv_rem;
            if (finish) begin
              state <= ST_DONE;
              note  <= NOTE_REST;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (!play) begin
              state <= ST_PAUSE;
              note  <= NOTE_REST;
              busy  <= 1'b0;
            end else begin
              note <= adv_note;
            end
          end
          ST_PAUSE: begin
            if (play) begin
              state <= ST_PLAY;
              note  <= adv_note;
              busy  <= 1'b1;
            end
          end
          ST_DONE: begin
            if (!play) begin
              state <= ST_IDLE;
              step  <= 5'd0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a 4-entry table and TICK_DIV=4.
// dut_a: LOOP=1 ARTIC=1, dut_b: LOOP=0 ARTIC=0, dut_c: SONG_LEN=1 LOOP=1 ARTIC=0.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst, play_a, play_b, restart;
  logic [4:0] note_a, step_a, note_b, step_b, note_c, step_c;
  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;

  int vectors     = 0;
  int miscompares = 0;

  // Hand-derived schedule: entries (3,1),(7,0),(12,2),(5,0) last 8,4,12,4
  // cycles; with articulation the final tick (4 cycles) of entries 0 and 2 rests.
  int ent_note [4] = '{3, 7, 12, 5};
  int ent_len  [4] = '{8, 4, 12, 4};
  int ent_rest [4] = '{4, 0, 4, 0};

  always #5 clk = ~clk;

  note_sequencer #(.TICK_DIV(4), .SONG_LEN(4), .LOOP(1), .ARTIC(1)) dut_a (
    .clk(clk), .rst(rst), .play(play_a), .restart(restart),
    .note(note_a), .step(step_a), .busy(busy_a), .done(done_a));

  note_sequencer #(.TICK_DIV(4), .SONG_LEN(4), .LOOP(0), .ARTIC(0)) dut_b (
    .clk(clk), .rst(rst), .play(play_b), .restart(restart),
    .note(note_b), .step(step_b), .busy(busy_b), .done(done_b));

  note_sequencer #(.TICK_DIV(4), .SONG_LEN(1), .LOOP(1), .ARTIC(0)) dut_c (
    .clk(clk), .rst(rst), .play(play_a), .restart(restart),
    .note(note_c), .step(step_c), .busy(busy_c), .done(done_c));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected note/step for the i-th output cycle after playback starts.
  function automatic void sched(input int i, input bit artic,
                                output logic [4:0] n, output logic [4:0] s);
    int t;
    t = i % 28;
    n = 5'd0;
    s = 5'd0;
    for (int k = 0; k < 4; k++) begin
      if (t >= 0 && t < ent_len[k]) begin
        s = 5'(k);
        n = (artic && t >= ent_len[k] - ent_rest[k]) ? 5'd0 : 5'(ent_note[k]);
        t = -1;
      end else if (t >= 0) begin
        t = t - ent_len[k];
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; play_a = 1'b0; play_b = 1'b0; restart = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; play_a = 1'b0; play_b = 1'b0; restart = 1'b0;
    cyc(); cyc();
    vectors++;
    if ({note_a, step_a, busy_a, done_a} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_a: got note=%0d step=%0d busy=%0b done=%0b, want all 0",
               note_a, step_a, busy_a, done_a);
    end
    vectors++;
    if ({note_b, step_b, busy_b, done_b} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_b: got note=%0d step=%0d busy=%0b done=%0b, want all 0",
               note_b, step_b, busy_b, done_b);
    end
    rst = 1'b0;
    cyc();
    vectors++;
    if ({note_c, step_c, busy_c, done_c} !== 12'd0) begin
      miscompares++;
      $display("FAIL idle_c: got note=%0d step=%0d busy=%0b done=%0b, want all 0",
               note_c, step_c, busy_c, done_c);
    end
  endtask

  task automatic test_playback_artic();
    logic [4:0] n, s;
    play_a = 1'b1;
    for (int i = 0; i < 36; i++) begin
      cyc();
      sched(i, 1'b1, n, s);
      vectors++;
      if ({note_a, step_a, busy_a, done_a} !== {n, s, 2'b10}) begin
        miscompares++;
        $display("FAIL artic_a cyc %0d: got note=%0d step=%0d busy=%0b done=%0b, want note=%0d step=%0d busy=1 done=0",
                 i, note_a, step_a, busy_a, done_a, n, s);
      end
      vectors++;
      if ({note_c, step_c, busy_c} !== {5'd3, 5'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL single_c cyc %0d: got note=%0d step=%0d busy=%0b, want note=3 step=0 busy=1",
                 i, note_c, step_c, busy_c);
      end
    end
    play_a = 1'b0;
    cyc();
    vectors++;
    if ({note_a, busy_a} !== 6'd0) begin
      miscompares++;
      $display("FAIL pause_a: got note=%0d busy=%0b, want note=0 busy=0", note_a, busy_a);
    end
    do_reset();
  endtask

  task automatic test_loop0();
    logic [4:0] n, s;
    play_b = 1'b1;
    for (int i = 0; i < 28; i++) begin
      cyc();
      sched(i, 1'b0, n, s);
      vectors++;
      if ({note_b, step_b, busy_b, done_b} !== {n, s, 2'b10}) begin
        miscompares++;
        $display("FAIL play_b cyc %0d: got note=%0d step=%0d busy=%0b done=%0b, want note=%0d step=%0d busy=1 done=0",
                 i, note_b, step_b, busy_b, done_b, n, s);
      end
    end
    cyc();
    vectors++;
    if ({note_b, step_b, busy_b, done_b} !== {5'd0, 5'd3, 2'b01}) begin
      miscompares++;
      $display("FAIL done_pulse: got note=%0d step=%0d busy=%0b done=%0b, want note=0 step=3 busy=0 done=1",
               note_b, step_b, busy_b, done_b);
    end
    cyc();
    vectors++;
    if ({note_b, step_b, busy_b, done_b} !== {5'd0, 5'd3, 2'b00}) begin
      miscompares++;
      $display("FAIL done_hold: got note=%0d step=%0d busy=%0b done=%0b, want note=0 step=3 busy=0 done=0",
               note_b, step_b, busy_b, done_b);
    end
    play_b = 1'b0;
    cyc();
    vectors++;
    if ({note_b, step_b, busy_b, done_b} !== 12'd0) begin
      miscompares++;
      $display("FAIL done_to_idle: got note=%0d step=%0d busy=%0b done=%0b, want all 0",
               note_b, step_b, busy_b, done_b);
    end
    do_reset();
  endtask

  task automatic test_pause();
    logic [4:0] n, s;
    play_b = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc();
      sched(i, 1'b0, n, s);
      vectors++;
      if ({note_b, step_b, busy_b} !== {n, s, 1'b1}) begin
        miscompares++;
        $display("FAIL pre_pause cyc %0d: got note=%0d step=%0d busy=%0b, want note=%0d step=%0d busy=1",
                 i, note_b, step_b, busy_b, n, s);
      end
    end
    play_b = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      vectors++;
      if ({note_b, step_b, busy_b} !== {5'd0, 5'd2, 1'b0}) begin
        miscompares++;
        $display("FAIL paused cyc %0d: got note=%0d step=%0d busy=%0b, want note=0 step=2 busy=0",
                 j, note_b, step_b, busy_b);
      end
    end
    play_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      sched(17 + k, 1'b0, n, s);
      vectors++;
      if ({note_b, step_b, busy_b} !== {n, s, 1'b1}) begin
        miscompares++;
        $display("FAIL resume cyc %0d: got note=%0d step=%0d busy=%0b, want note=%0d step=%0d busy=1",
                 k, note_b, step_b, busy_b, n, s);
      end
    end
    do_reset();
  endtask

  task automatic test_restart();
    logic [4:0] n, s;
    play_a = 1'b1;
    for (int i = 0; i < 28; i++) cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cyc();
      sched(i, 1'b1, n, s);
      vectors++;
      if ({note_a, step_a, busy_a} !== {n, s, 1'b1}) begin
        miscompares++;
        $display("FAIL restart cyc %0d: got note=%0d step=%0d busy=%0b, want note=%0d step=%0d busy=1",
                 i, note_a, step_a, busy_a, n, s);
      end
    end
    play_a = 1'b0;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    vectors++;
    if ({note_a, step_a, busy_a, done_a} !== 12'd0) begin
      miscompares++;
      $display("FAIL restart_idle: got note=%0d step=%0d busy=%0b done=%0b, want all 0",
               note_a, step_a, busy_a, done_a);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [4:0] n, s;
    play_a = 1'b1;
    for (int i = 0; i < 16; i++) cyc();
    rst = 1'b1;
    cyc();
    vectors++;
    if ({note_a, step_a, busy_a, done_a} !== 12'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got note=%0d step=%0d busy=%0b done=%0b, want all 0",
               note_a, step_a, busy_a, done_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      sched(i, 1'b1, n, s);
      vectors++;
      if ({note_a, step_a, busy_a} !== {n, s, 1'b1}) begin
        miscompares++;
        $display("FAIL after_reset cyc %0d: got note=%0d step=%0d busy=%0b, want note=%0d step=%0d busy=1",
                 i, note_a, step_a, busy_a, n, s);
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_playback_artic();
    test_loop0();
    test_pause();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Melody sequencer that sits directly upstream of the `sound` tone generator. It steps through a fixed song table of (note, duration) entries at a programmable tempo and drives the 5-bit `note` index that `sound` converts into its 9-bit `value` waveform. It supports play/pause, restart, single-shot or looping playback, and optional articulation gaps between notes.

## Interface
Parameters:
- `TICK_DIV`, default 6_250_000: clock cycles per duration tick (1/8 s at 50 MHz); legal range ≥ 2.
- `SONG_LEN`, default 32: number of song table entries; legal range 1..32.
- `LOOP`, default 1: 1 wraps to entry 0 after the last entry; 0 stops in DONE.
- `ARTIC`, default 1: 1 forces rest (note 0) during the final tick of every entry whose duration is ≥ 2 ticks.

Ports:
- `clk` input, 1 bit: the single clock. Everything is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `play` input, 1 bit: level signal; 1 runs playback, 0 pauses it.
- `restart` input, 1 bit: single-cycle pulse; returns playback to entry 0.
- `note` output, 5 bits: registered note index for `sound`; 0 means rest.
- `step` output, 5 bits: registered index of the current table entry.
- `busy` output, 1 bit: high while in PLAY.
- `done` output, 1 bit: single-cycle pulse on entry to DONE.

## Operation
- Song table: a constant ROM of `SONG_LEN` entries, each {note[4:0], dur[3:0]}. An entry lasts (dur+1) ticks, i.e. 1..16 ticks.
- Counters:
  - `pre` counts 0..TICK_DIV-1 and produces `tick` on the cycle it wraps.
  - `rem` holds the ticks remaining in the current entry.
- States:
  - IDLE: `note`=0, `step`=0, `pre`=0.
    - If `play`=1, go to PLAY and load entry 0 (`rem`=dur).
  - PLAY: `note` equals the ROM note of the current entry.
    - Exception: if ARTIC=1, dur≥1 and `rem`=0, `note`=0.
    - `pre` advances every cycle.
    - On `tick` with `rem`>0: decrement `rem`.
    - On `tick` with `rem`=0, at the last entry: with LOOP=1 go to `step`=0 and reload; with LOOP=0 go to DONE.
    - On `tick` with `rem`=0, otherwise: `step`+1 and reload `rem`.
    - If `play`=0, go to PAUSE.
  - PAUSE: `note`=0; `pre`, `rem` and `step` are frozen.
    - If `play`=1, return to PLAY with no loss of progress.
  - DONE: `note`=0 and `step` holds the last index.
    - If `play`=0, go to IDLE.
- Priority: `rst` > `restart` > `play`/`tick` logic.
  - `restart` in any state clears `step`, `pre` and `rem`-reload to entry 0.
  - Next state after `restart` is PLAY if `play`=1, else IDLE.
  - `restart` takes effect even when it coincides with a `tick`.
- Widths: `step` is 5 bits and never exceeds SONG_LEN-1. `rem` is 4 bits. `pre` is clog2(TICK_DIV) bits.

## Timing
- Reset values: state IDLE, `note`=0, `step`=0, `busy`=0, `done`=0, `pre`=0, `rem`=0.
- All outputs are registered. Every change appears on the cycle after its causing condition is sampled.
- `play` sampled high in IDLE at edge N: `busy`=1 and `note`=entry0.note from edge N+1.
- An entry occupies exactly (dur+1)·TICK_DIV cycles of PLAY time. Pause cycles are not counted.
- Entry change: `step`/`note` update on the edge after the final `tick`.
- `done`: high for exactly one cycle, the first cycle in DONE. `busy` falls on the same edge.
- SONG_LEN=1 with LOOP=1: the single entry repeats indefinitely; `step` stays 0.
- Reset mid-playback: all outputs return to their reset values on the next edge. No residual note is output.

## Structure
- `sound_pkg` holds:
  - the state encoding (IDLE, PLAY, PAUSE, DONE);
  - the song entry field widths (NOTE_W=5, DUR_W=4);
  - the note 0 = rest constant, which is shared with `sound`.
- Sub-module `tempo_tick`: the `pre` prescaler.
  - Inputs: `clk`, `rst`, `en`, `clr`. Output: `tick`.
  - `en` is low in PAUSE. `clr` is driven by IDLE or `restart`.
- The song ROM is a case statement inside `note_sequencer`.

## Test plan
Bench configuration: TICK_DIV=4, SONG_LEN=4, table {(3,1),(7,0),(12,2),(5,0)}.
- Basic playback: reset, then `play`=1 → `note` follows 3 for 8 cycles, 7 for 4, 12 for 12, 5 for 4. With ARTIC=0 this is exact; with ARTIC=1, note=0 during the final tick of entries 0 and 2.
- LOOP=0: `play` held high → after 28 cycles, `done` pulses once; `busy`=0, `note`=0, `step`=3. Dropping `play` returns to IDLE.
- Pause: `play` low for 10 cycles mid-entry 2 → `note`=0 during the pause. After resume, entry 2 completes its remaining cycles exactly, with a total active span of 12.
- Restart: `restart` pulse during entry 3, coinciding with `tick` → next cycle `step`=0, `note`=3, and entry 0 lasts a full 8 cycles.
- Reset: `rst` during PLAY → all outputs at reset values on the next edge. With `play` still high, playback restarts from entry 0 one cycle after `rst` falls.
